// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared types and constants for the pipelined Kogge-Stone adder.
// Subtract support is enabled by defining PIPELINED_PREFIX_ADDER_SUB_EN.
package pipelined_prefix_adder_pkg;

    localparam int MIN_WIDTH = 8;
    localparam int MAX_WIDTH = 128;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix operator: hi is the more significant group, lo the adjacent lower one.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// Valid/ready operand and result bundle of pipelined_prefix_adder.
// PIPELINED_PREFIX_ADDER_SUB_EN adds the sub input and overflow output.
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
    logic             sub;
    logic             overflow;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
        output sub,
        input  overflow,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
        input  sub,
        output overflow,
`endif
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/pipelined_prefix_adder_prefix_level.sv
// One Kogge-Stone prefix level (distance SPAN) followed by its register rank.
// Position 0 carries cin as g[-1]; position j+1 is bit j of the operands.
module prefix_level
    import pipelined_prefix_adder_pkg::*;
#(
    parameter int NPOS  = 65,
    parameter int WIDTH = 64,
    parameter int SPAN  = 1
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  gp_t  [NPOS-1:0]      i_gp,
    input  logic [WIDTH-1:0]     i_p0,
    output logic                 o_valid,
    output gp_t  [NPOS-1:0]      o_gp,
    output logic [WIDTH-1:0]     o_p0
);

    gp_t  [NPOS-1:0]  w_gp;
    logic             r_valid;
    gp_t  [NPOS-1:0]  r_gp;
    logic [WIDTH-1:0] r_p0;

    for (genvar j = 0; j < NPOS; j++) begin : g_pos
        if (j >= SPAN) begin : g_combine
            assign w_gp[j] = gp_combine(i_gp[j], i_gp[j-SPAN]);
        end else begin : g_pass
            assign w_gp[j] = i_gp[j];
        end
    end

    // NOTE: data registers are reset along with the valid bit so that sum/cout read 0 while cleared.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_valid <= 1'b0;
            r_gp    <= '0;
            r_p0    <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_gp    <= w_gp;
            r_p0    <= i_p0;
        end
    end

    assign o_valid = r_valid;
    assign o_gp    = r_gp;
    assign o_p0    = r_p0;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder: LOG2W prefix levels, one register rank each, global stall.
// Defining PIPELINED_PREFIX_ADDER_SUB_EN adds subtraction (sub) and signed overflow.
module pipelined_prefix_adder
    import pipelined_prefix_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input logic                     clk,
    input logic                     clear_n,
    pipelined_prefix_adder_if.slave bus
);

    localparam int NPOS = WIDTH + 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("pipelined_prefix_adder: WIDTH must be a power of two in 8..128");
    end
    if (LOG2W != $clog2(WIDTH)) begin : g_bad_log2w
        $error("pipelined_prefix_adder: LOG2W must equal $clog2(WIDTH)");
    end

    logic                 w_stall;
    logic [WIDTH-1:0]     w_b_eff;
    logic                 w_cin_eff;
    gp_t  [NPOS-1:0]      w_gp_in;
    gp_t  [NPOS-1:0]      w_gp_chain [LOG2W+1];
    logic [WIDTH-1:0]     w_p_chain  [LOG2W+1];
    logic                 w_v_chain  [LOG2W+1];
    gp_t  [NPOS-1:0]      w_last;
    logic [WIDTH-1:0]     w_carry;
    logic                 w_cout;
    logic                 w_unused_p;

`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_eff = bus.cin | bus.sub;
`else
    assign w_b_eff   = bus.b;
    assign w_cin_eff = bus.cin;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_gp_in    = '0;
        w_gp_in[0] = '{g: w_cin_eff, p: 1'b0};
        for (int i = 0; i < WIDTH; i++) begin
            w_gp_in[i+1] = '{g: bus.a[i] & w_b_eff[i], p: bus.a[i] ^ w_b_eff[i]};
        end
    end

    assign w_stall       = w_v_chain[LOG2W] && !bus.out_ready;
    assign w_gp_chain[0] = w_gp_in;
    assign w_p_chain[0]  = bus.a ^ w_b_eff;
    assign w_v_chain[0]  = bus.in_valid && !w_stall;

    for (genvar k = 0; k < LOG2W; k++) begin : g_level
        prefix_level #(
            .NPOS  (NPOS),
            .WIDTH (WIDTH),
            .SPAN  (1 << k)
        ) u_level (
            .clk     (clk),
            .clear_n (clear_n),
            .i_en    (!w_stall),
            .i_valid (w_v_chain[k]),
            .i_gp    (w_gp_chain[k]),
            .i_p0    (w_p_chain[k]),
            .o_valid (w_v_chain[k+1]),
            .o_gp    (w_gp_chain[k+1]),
            .o_p0    (w_p_chain[k+1])
        );
    end

    assign w_last = w_gp_chain[LOG2W];

    // Position i resolves the carry into bit i; the top position still lacks cin.
    always_comb begin
        w_carry    = '0;
        w_unused_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i] = w_last[i].g;
            w_unused_p = w_unused_p ^ w_last[i].p;
        end
    end

    assign w_cout        = w_last[WIDTH].g | (w_last[WIDTH].p & w_last[0].g);
    assign bus.sum       = w_p_chain[LOG2W] ^ w_carry;
    assign bus.cout      = w_cout;
    assign bus.out_valid = w_v_chain[LOG2W];
    assign bus.in_ready  = !w_stall;

`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
    assign bus.overflow  = w_last[WIDTH-1].g ^ w_cout;
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench: directed table and multi-cycle sequences at WIDTH=64,
// plus randomised scoreboard sweeps at WIDTH=8, 32 and 128.
module tb_pipelined_prefix_adder;

    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clear_n;
    int   total = 0;
    int   bad = 0;
    int   sweep_done = 0;

    pipelined_prefix_adder_if #(.WIDTH(W)) bus ();

    pipelined_prefix_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        bus.a         = v.a;
        bus.b         = v.b;
        bus.cin       = v.cin;
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
        bus.sub       = v.sub;
`endif
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #1;
        end
        check($sformatf("vec%0d_latency", idx), lat, 6);
        check($sformatf("vec%0d_sum", idx), bus.sum, v.exp_sum);
        check($sformatf("vec%0d_cout", idx), bus.cout, v.exp_cout);
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
        check($sformatf("vec%0d_overflow", idx), bus.overflow, v.exp_ovf);
        bus.sub = 1'b0;
`endif
    endtask

    initial begin
        vec_t         vecs[$];
        logic [W:0]   q[$];
        logic [W:0]   e;
        logic [W-1:0] ra, rb;
        logic         rc;
        int i, nres, first, last, n, got, cnt;

        clear_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);

        vecs.push_back(vec_t'{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, cin: 1'b0, sub: 1'b0,
                              exp_sum: 64'd0, exp_cout: 1'b1, exp_ovf: 1'b0});
        vecs.push_back(vec_t'{a: 64'd0, b: 64'd0, cin: 1'b1, sub: 1'b0,
                              exp_sum: 64'd1, exp_cout: 1'b0, exp_ovf: 1'b0});
        vecs.push_back(vec_t'{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, cin: 1'b1, sub: 1'b0,
                              exp_sum: 64'hFFFF_FFFF_FFFF_FFFF, exp_cout: 1'b1, exp_ovf: 1'b0});
        vecs.push_back(vec_t'{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, cin: 1'b0, sub: 1'b0,
                              exp_sum: 64'd0, exp_cout: 1'b1, exp_ovf: 1'b1});
        vecs.push_back(vec_t'{a: 64'h5555_5555_5555_5555, b: 64'hAAAA_AAAA_AAAA_AAAA, cin: 1'b0, sub: 1'b0,
                              exp_sum: 64'hFFFF_FFFF_FFFF_FFFF, exp_cout: 1'b0, exp_ovf: 1'b0});
        vecs.push_back(vec_t'{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, cin: 1'b0, sub: 1'b0,
                              exp_sum: 64'h8000_0000_0000_0000, exp_cout: 1'b0, exp_ovf: 1'b1});
        vecs.push_back(vec_t'{a: 64'h1234_5678_9ABC_DEF0, b: 64'h0FED_CBA9_8765_4321, cin: 1'b1, sub: 1'b0,
                              exp_sum: 64'h2222_2222_2222_2212, exp_cout: 1'b0, exp_ovf: 1'b0});
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
        vecs.push_back(vec_t'{a: 64'h80, b: 64'd1, cin: 1'b0, sub: 1'b1,
                              exp_sum: 64'h7F, exp_cout: 1'b1, exp_ovf: 1'b0});
        vecs.push_back(vec_t'{a: 64'd5, b: 64'd7, cin: 1'b0, sub: 1'b1,
                              exp_sum: 64'hFFFF_FFFF_FFFF_FFFE, exp_cout: 1'b0, exp_ovf: 1'b0});
        vecs.push_back(vec_t'{a: 64'h8000_0000_0000_0000, b: 64'd1, cin: 1'b0, sub: 1'b1,
                              exp_sum: 64'h7FFF_FFFF_FFFF_FFFF, exp_cout: 1'b1, exp_ovf: 1'b1});
`endif
        for (int k = 0; k < vecs.size(); k++) run_vector(vecs[k], k);

        // Back-to-back stream a=i, b=2i, cin=i[0]: results 3i+i[0], in order, no gaps.
        i = 1; nres = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 300 && nres < 100; cyc++) begin
            @(negedge clk);
            if (i <= 100) begin
                bus.a        = 64'(i);
                bus.b        = 64'(2 * i);
                bus.cin      = i[0];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                nres++;
                check("b2b_sum", bus.sum, 64'(3 * nres + nres % 2));
                check("b2b_cout", bus.cout, 0);
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (bus.in_valid && bus.in_ready) i++;
        end
        check("b2b_count", nres, 100);
        check("b2b_no_gaps", last - first + 1, 100);

        // Stall: six beats in flight, out_ready low for five cycles, then drain.
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 6; cyc++) begin
            @(negedge clk);
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(0, 1));
            bus.a = ra; bus.b = rb; bus.cin = rc; bus.in_valid = 1'b1;
            #1;
            if (bus.in_ready) begin
                q.push_back({1'b0, ra} + {1'b0, rb} + (W+1)'(rc));
                n++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("stall_out_valid", bus.out_valid, 1);
        for (int s = 0; s < 5; s++) begin
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_sum_held", {bus.cout, bus.sum}, q[0]);
            @(negedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) begin
                got++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("stall_drain", {bus.cout, bus.sum}, e);
                end else begin
                    check("stall_duplicate", 1, 0);
                end
            end
            @(negedge clk);
            #1;
        end
        check("stall_count", got, 6);

        // Mid-operation reset with four beats in flight.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.a = {$urandom(), $urandom()} | 64'h1;
            bus.b = {$urandom(), $urandom()};
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        clear_n      = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_sum", bus.sum, 0);
        check("midrst_cout", bus.cout, 0);
        @(negedge clk);
        clear_n = 1'b1;
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        check("midrst_no_ghosts", cnt, 0);

        for (int c = 0; c < 5000 && sweep_done < 3; c++) @(posedge clk);
        check("sweeps_finished", sweep_done, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Randomised sweeps against a plain-arithmetic model with a result queue.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int SW = (gi == 0) ? 8 : (gi == 1) ? 32 : 128;

        logic s_rst_n;
        pipelined_prefix_adder_if #(.WIDTH(SW)) sbus ();

        pipelined_prefix_adder #(.WIDTH(SW)) u_dut (
            .clk     (clk),
            .clear_n (s_rst_n),
            .bus     (sbus)
        );

        function automatic logic [SW+1:0] model(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                                 input logic cin, input logic sub);
            logic [SW-1:0] bb;
            logic [SW:0]   full;
            logic          ovf;
            bb   = sub ? ~b : b;
            full = {1'b0, a} + {1'b0, bb} + (SW+1)'(cin | sub);
            ovf  = (a[SW-1] == bb[SW-1]) && (full[SW-1] != a[SW-1]);
            return {ovf, full};
        endfunction

        initial begin
            logic [SW+1:0] exp_q[$];
            logic [SW+1:0] e;
            logic [127:0]  ra, rb;
            logic          rc, rs;

            s_rst_n        = 1'b0;
            sbus.in_valid  = 1'b0;
            sbus.a         = '0;
            sbus.b         = '0;
            sbus.cin       = 1'b0;
            sbus.out_ready = 1'b0;
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
            sbus.sub       = 1'b0;
`endif
            repeat (2) @(negedge clk);
            s_rst_n = 1'b1;
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clk);
                ra = {$urandom(), $urandom(), $urandom(), $urandom()};
                rb = {$urandom(), $urandom(), $urandom(), $urandom()};
                case ($urandom_range(0, 7))
                    0: ra = '1;
                    1: begin ra = '1; rb = 128'd1; end
                    2: rb = '1;
                    default: ;
                endcase
                rc = 1'($urandom_range(0, 1));
                rs = 1'b0;
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
                rs = 1'($urandom_range(0, 1));
                sbus.sub = rs;
`endif
                sbus.a   = ra[SW-1:0];
                sbus.b   = rb[SW-1:0];
                sbus.cin = rc;
                if (cyc < 500) begin
                    sbus.in_valid  = ($urandom_range(0, 3) != 0);
                    sbus.out_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    sbus.in_valid  = 1'b0;
                    sbus.out_ready = 1'b1;
                end
                #1;
                check($sformatf("w%0d_in_ready", SW), sbus.in_ready,
                      !(sbus.out_valid && !sbus.out_ready));
                if (sbus.out_valid && sbus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("w%0d_spurious", SW), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("w%0d_result", SW), {sbus.cout, sbus.sum}, e[SW:0]);
`ifdef PIPELINED_PREFIX_ADDER_SUB_EN
                        check($sformatf("w%0d_overflow", SW), sbus.overflow, e[SW+1]);
`endif
                    end
                end
                if (sbus.in_valid && sbus.in_ready) exp_q.push_back(model(ra[SW-1:0], rb[SW-1:0], rc, rs));
            end
            check($sformatf("w%0d_leftover", SW), exp_q.size(), 0);
            sweep_done++;
        end
    end

endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 Parameter WIDTH, default 64: operand width; SHALL be a power of two, 8..128; elaboration SHALL fail otherwise.
REQ-002 Parameter LOG2W, default $clog2(WIDTH): number of prefix levels; SHALL NOT be overridden by instantiators.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 clear_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and cin present this cycle.
REQ-006 in_ready  output  1  pipeline accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  sum/cout hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 sum  output  WIDTH  result bits.
REQ-013 cout  output  1  carry-out of bit WIDTH-1.

Function
REQ-014 Result SHALL be {cout,sum} = a + b' + cin (b' = b, or ~b when subtracting per REQ-029), modulo 2^(WIDTH+1).
REQ-015 Algorithm SHALL be Kogge-Stone: bitwise g=a&b', p=a^b'; cin folded in as g[-1]; level k (0..LOG2W-1) combines span 2^k; final sum = p ^ {carries[WIDTH-2:0], cin}.
REQ-016 One register rank SHALL follow each prefix level; latency from accepted input to out_valid SHALL be exactly LOG2W cycles (6 at WIDTH=64) when not stalled.
REQ-017 Each rank SHALL carry a valid bit; a beat is accepted when in_valid && in_ready.
REQ-018 Global stall: stall = out_valid && !out_ready; in_ready = !stall; while stalled every rank, including the valid bits, SHALL hold.
REQ-019 When not stalled, bubbles (valid=0) SHALL advance like data; throughput SHALL be one result per cycle with out_ready held high.
REQ-020 sum, cout SHALL hold stable while out_valid && !out_ready.
REQ-021 in_ready SHALL depend combinationally only on out_valid and out_ready, never on in_valid.
REQ-022 Carry wrap: all-ones + 1 SHALL give sum=0, cout=1; no other flag is generated.
REQ-023 Data registers of invalid beats are don't-care; only the valid bits are control state.

Reset
REQ-024 While clear_n=0, all valid bits SHALL be 0 and out_valid SHALL be 0.
REQ-025 While clear_n=0, sum and cout SHALL be 0, with all data ranks cleared.
REQ-026 On release of clear_n, in_ready SHALL be 1 in the same cycle.
REQ-027 Assertion mid-operation SHALL discard every in-flight beat; no result of a beat accepted before reset SHALL appear afterwards.

Configuration
REQ-028 Macro PIPELINED_PREFIX_ADDER_SUB_EN SHALL control subtract support.
REQ-029 With the macro defined: extra port sub (input, 1, sampled with in_valid); when sub=1, b'=~b and effective carry-in = cin | sub; the design SHALL also add overflow (output, 1, signed overflow = carry into MSB ^ cout), pipelined alongside sum and reset to 0.
REQ-030 Without the macro: no sub or overflow ports; b'=b.

Structure
REQ-031 Shared package pipelined_prefix_adder_pkg SHALL hold the WIDTH bounds constants (MIN_WIDTH=8, MAX_WIDTH=128) and the gp_t typedef (packed struct: g, p).
REQ-032 Sub-module prefix_level SHALL implement one combinational level (parameter SPAN) plus its register rank with hold enable; the top SHALL instantiate LOG2W of them in a generate loop.

Verification
REQ-033 WIDTH=64: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0, cout=1 on out_valid exactly 6 cycles after accept.
REQ-034 WIDTH=64: back-to-back beats a=i, b=2i, cin=i[0] for i=1..100, out_ready=1 -> 100 consecutive results 3i+i[0], in order, no gaps.
REQ-035 Stall: out_ready=0 for 5 cycles with 6 beats in flight -> in_ready=0, sum held, no beat lost or duplicated after release.
REQ-036 Reset: assert clear_n=0 with 4 beats in flight -> out_valid=0, sum=0 immediately; after release none of the 4 beats emerges.
REQ-037 SUB_EN, WIDTH=8: a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, overflow=1; a=5, b=7, sub=1 -> sum=8'hFE, cout=0, overflow=0.
REQ-038 Randomised sweep at WIDTH=8,32,128 against a behavioural a+b'+cin model, with random out_ready -> zero mismatches.
